// File: rtl/adsr_envelope.sv
// ADSR envelope generator with output VCA for a single voice.
// Advances one envelope step per sample_en strobe and scales the incoming
// oscillator sample by the envelope value held before that step.
module adsr_envelope #(
  parameter int ENV_W    = 16,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic                       gate,
  input  logic [ENV_W-1:0]           attack_inc,
  input  logic [ENV_W-1:0]           decay_dec,
  input  logic [ENV_W-1:0]           sustain_lvl,
  input  logic [ENV_W-1:0]           release_dec,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       sample_valid,
  output logic [ENV_W-1:0]           env_out,
  output logic [2:0]                 state_out,
  output logic                       busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ATTACK  = 3'd1;
  localparam logic [2:0] ST_DECAY   = 3'd2;
  localparam logic [2:0] ST_SUSTAIN = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [ENV_W-1:0] ENV_MAX = '1;

  logic [2:0]       state;
  logic [2:0]       state_nxt;
  logic [ENV_W-1:0] env;
  logic [ENV_W-1:0] env_nxt;

  // One extra bit keeps the attack sum from wrapping and lets the decay
  // difference go negative so it can be compared signed against sustain.
  logic [ENV_W:0] attack_sum;
  logic [ENV_W:0] decay_diff;

  logic signed [SAMPLE_W+ENV_W:0] product;
  logic                           unused_product_bits;

  assign attack_sum = {1'b0, env} + {1'b0, attack_inc};
  assign decay_diff = {1'b0, env} - {1'b0, decay_dec};

  // Envelope is treated as a non-negative signed operand so full scale never
  // flips the sign of the sample; only the upper sample-width slice is kept.
  assign product             = sample_in * $signed({1'b0, env});
  assign unused_product_bits = ^{product[SAMPLE_W+ENV_W], product[ENV_W-1:0]};

  assign env_out   = env;
  assign state_out = state;

  // Next-step decision: gate-low forces release, otherwise each phase steps
  // toward its target and jumps to the next phase when it would overshoot.
  always_comb begin
    state_nxt = state;
    env_nxt   = env;
    case (state)
      ST_IDLE: begin
        if (gate) state_nxt = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (!gate) begin
          state_nxt = ST_RELEASE;
        end else if ((attack_inc == '0) || (attack_sum >= {1'b0, ENV_MAX})) begin
          env_nxt   = ENV_MAX;
          state_nxt = ST_DECAY;
        end else begin
          env_nxt = attack_sum[ENV_W-1:0];
        end
      end
      ST_DECAY: begin
        if (!gate) begin
          state_nxt = ST_RELEASE;
        end else if ((decay_dec == '0) ||
                     ($signed(decay_diff) <= $signed({1'b0, sustain_lvl}))) begin
          env_nxt   = sustain_lvl;
          state_nxt = ST_SUSTAIN;
        end else begin
          env_nxt = decay_diff[ENV_W-1:0];
        end
      end
      ST_SUSTAIN: begin
        if (!gate) begin
          state_nxt = ST_RELEASE;
        end else begin
          env_nxt = sustain_lvl;
        end
      end
      ST_RELEASE: begin
        if (gate) begin
          state_nxt = ST_ATTACK;
        end else if ((release_dec == '0) || (env <= release_dec)) begin
          env_nxt   = '0;
          state_nxt = ST_IDLE;
        end else begin
          env_nxt = env - release_dec;
        end
      end
      default: begin
        env_nxt   = '0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, envelope and VCA output advance only on sample ticks; the valid
  // strobe follows every tick by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      env          <= '0;
      busy         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_en;
      if (sample_en) begin
        state      <= state_nxt;
        env        <= env_nxt;
        busy       <= (state_nxt != ST_IDLE);
        sample_out <= product[SAMPLE_W+ENV_W-1:ENV_W];
      end
    end
  end

endmodule

// File: doc/adsr_envelope.md
Name: adsr_envelope

Overview:
- Per-voice ADSR envelope generator with an output VCA. Sits downstream of the sample-rate clock-enable divider and advances one step per sample_en pulse (one fast-clock cycle wide, at the audio sample rate).
- Scales the oscillator sample by the current envelope value and presents the result to the mixer.
- All logic runs on the fast system clock. No derived clocks.

Parameters:
- ENV_W, 16, envelope value width (unsigned, full scale = 2^ENV_W-1)
- SAMPLE_W, 16, signed audio sample width

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- sample_en  input  1  sample-rate strobe, one clk cycle wide
- gate  input  1  note on (1) / note off (0), level-sensitive
- attack_inc  input  ENV_W  envelope increment per sample in ATTACK
- decay_dec  input  ENV_W  decrement per sample in DECAY
- sustain_lvl  input  ENV_W  sustain level
- release_dec  input  ENV_W  decrement per sample in RELEASE
- sample_in  input  SAMPLE_W  signed oscillator sample
- sample_out  output  SAMPLE_W  signed enveloped sample, registered
- sample_valid  output  1  one-cycle pulse, sample_out updated
- env_out  output  ENV_W  current envelope value, registered
- state_out  output  3  current state encoding
- busy  output  1  high when state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, env_out=0, sample_out=0, sample_valid=0, busy=0, state_out=0.
- State encoding: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4. Codes 5..7 are illegal and recover to IDLE with env=0 on the next sample_en.
- State and env change only on clk edges where sample_en=1. Otherwise all registers hold, and inputs are ignored.
- Gate-low priority: in ATTACK, DECAY or SUSTAIN, gate=0 at a sample_en moves to RELEASE on that tick. env is held on that tick; decrement starts on the next tick.
- IDLE: gate=1 -> ATTACK, with env unchanged (0). Step begins on the next tick.
- ATTACK:
  - if attack_inc=0 or env + attack_inc >= MAX: env=MAX and go to DECAY.
  - otherwise env += attack_inc.
  - Addition uses ENV_W+1 bits; no wrap-around.
- DECAY:
  - if decay_dec=0 or env - decay_dec <= sustain_lvl (signed compare, ENV_W+1 bits): env=sustain_lvl and go to SUSTAIN.
  - otherwise env -= decay_dec.
  - If sustain_lvl = MAX, DECAY lasts exactly one tick.
- SUSTAIN: env=sustain_lvl every tick, so live changes are tracked.
- RELEASE:
  - gate=1 -> ATTACK. Retrigger from the current env; no reset to 0.
  - else if release_dec=0 or env <= release_dec: env=0 and go to IDLE.
  - else env -= release_dec.
- VCA:
  - On each sample_en edge, sample_out <= bits [SAMPLE_W+ENV_W-1:ENV_W] of (sample_in x {0,env_out}), a signed (SAMPLE_W+ENV_W+1)-bit product.
  - The multiply uses the env value before that tick's update.
  - Latency: sample_out and sample_valid appear one clk after the sample_en edge. sample_valid is high for exactly that one cycle.
  - With env=MAX the gain is (2^ENV_W-1)/2^ENV_W, so -32768 maps to -32768 and 32767 maps to 32766. With env=0 the output is 0.
- busy and state_out are registered copies of the state. Transitions are visible one clk after the deciding sample_en edge.
- Reset asserted mid-note: immediate return to reset values. The next gate=1 at a sample_en starts from IDLE.
- Step inputs may change at any time; the value present at each sample_en edge is the one used.

Test Plan:
- Reset release, sample_en every 1000 clk, gate=0 -> state_out=0, env_out=0, busy=0, sample_valid pulses each tick with sample_out=0.
- gate=1, attack_inc=0x4000, decay_dec=0x1000, sustain_lvl=0xC000, sample_in=0x4000 -> env_out sequence 0, 0x4000, 0x8000, 0xC000, 0xFFFF (DECAY), 0xEFFF, 0xDFFF, 0xCFFF, 0xC000 (SUSTAIN); sample_out = 0x3FFF when env=0xFFFF.
- From SUSTAIN at 0xC000, gate=0, release_dec=0x5000 -> one tick hold at RELEASE, then 0x7000, 0x2000, 0x0000 with state IDLE and busy=0.
- In RELEASE at env=0x7000, gate=1, attack_inc=0x8000 -> ATTACK, then 0xF000, then 0xFFFF and DECAY (saturation, no wrap).
- attack_inc=0, decay_dec=0, release_dec=0 -> ATTACK jumps to 0xFFFF in one tick, DECAY jumps to sustain in one tick, release jumps to 0 in one tick.
- Assert rst low while in DECAY between sample_en pulses -> outputs cleared that same cycle without a clk edge; sample_en held high continuously does not corrupt the sequence, since one step occurs per clk.
